// File: rtl/sw_color_conditioner_pkg.sv
// Shared colour-bus geometry for the switch conditioner and the GPU colour input.
package sw_color_conditioner_pkg;

  localparam int CHANNEL_BITS  = 4;
  localparam int CHANNEL_COUNT = 4;

  function automatic int color_width(input int bits, input int count);
    return bits * count;
  endfunction

  localparam int COLOR_W = color_width(CHANNEL_BITS, CHANNEL_COUNT);

  typedef logic [COLOR_W-1:0] color_t;

endpackage

// File: rtl/sw_color_conditioner_if.sv
// Switch-in / colour-out bundle between the board pins, the conditioner and the GPU.
interface sw_color_conditioner_if #(
  parameter int W = 16
);
  logic [W-1:0] sw_raw;
  logic         frame_start;
  logic [W-1:0] color;
  logic         color_update;
  logic         pending;

  modport master (
    output sw_raw, frame_start,
    input  color, color_update, pending
  );

  modport slave (
    input  sw_raw, frame_start,
    output color, color_update, pending
  );
endinterface

// File: rtl/sw_color_conditioner_debounce.sv
// One switch bit: SYNC_STAGES-deep synchroniser followed by a restart-on-bounce debounce counter.
module sw_debounce_bit #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_BITS        = 19
) (
  input  logic clk,
  input  logic aresetn,
  input  logic din_async,
  output logic dout_stable
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_BITS-1:0]    cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   sw_sync;

  assign sw_sync = sync_q[SYNC_STAGES-1];
  assign sync_d  = {sync_q[SYNC_STAGES-2:0], din_async};

  // Any sample matching the accepted level restarts the count, so only an
  // unbroken run of DEBOUNCE_CYCLES differing samples flips the output.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sw_sync == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = sw_sync;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign dout_stable = stable_q;

endmodule

// File: rtl/sw_color_conditioner.sv
// Debounces the board switches and hands the result to the GPU only at frame start.
module sw_color_conditioner
  import sw_color_conditioner_pkg::*;
#(
  parameter int CHANNEL_BITS    = sw_color_conditioner_pkg::CHANNEL_BITS,
  parameter int CHANNEL_COUNT   = sw_color_conditioner_pkg::CHANNEL_COUNT,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_BITS        = 19,
  parameter logic [CHANNEL_COUNT*CHANNEL_BITS-1:0] RESET_COLOR = '0
) (
  input  logic                   clk,
  input  logic                   aresetn,
  sw_color_conditioner_if.slave  bus
);

  localparam int W = color_width(CHANNEL_BITS, CHANNEL_COUNT);

  logic [W-1:0] stable;
  logic [W-1:0] color_q, color_d;
  logic         update_q, update_d;
  logic         pending_q, pending_d;

  for (genvar g = 0; g < W; g++) begin : g_bit
    sw_debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_BITS        (CNT_BITS)
    ) u_db (
      .clk         (clk),
      .aresetn     (aresetn),
      .din_async   (bus.sw_raw[g]),
      .dout_stable (stable[g])
    );
  end

  // pending compares against the colour being committed this edge, so it
  // drops in the same cycle the update pulse appears.
  always_comb begin
    color_d  = color_q;
    update_d = 1'b0;
    if (bus.frame_start && (stable != color_q)) begin
      color_d  = stable;
      update_d = 1'b1;
    end
    pending_d = (stable != color_d);
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      color_q   <= RESET_COLOR;
      update_q  <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      color_q   <= color_d;
      update_q  <= update_d;
      pending_q <= pending_d;
    end
  end

  assign bus.color        = color_q;
  assign bus.color_update = update_q;
  assign bus.pending      = pending_q;

endmodule

// File: tb/tb_sw_color_conditioner.sv
// Directed bench for sw_color_conditioner with a per-cycle behavioural reference.
module tb_sw_color_conditioner;

  localparam int W   = 16;
  localparam int DEB = 4;
  localparam logic [W-1:0] RC = 16'h0F0F;

  logic clk = 1'b0;
  logic aresetn;
  int   checks = 0;
  int   failures = 0;

  sw_color_conditioner_if #(.W(W)) bus();

  sw_color_conditioner #(
    .CHANNEL_BITS    (4),
    .CHANNEL_COUNT   (4),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (DEB),
    .CNT_BITS        (3),
    .RESET_COLOR     (RC)
  ) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference: raw switches seen two edges late, a bit is accepted after
  // DEB consecutive late samples disagree with it, commits only on frame_start.
  logic [W-1:0] m_s0, m_s1, m_stable, m_color, old_stable, old_color;
  int           m_run [W];
  logic         m_upd, m_pend;
  bit           m_valid = 0;

  always @(posedge clk) begin
    if (!aresetn) begin
      m_s0 = '0; m_s1 = '0; m_stable = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
      m_color = RC; m_upd = 1'b0; m_pend = 1'b0; m_valid = 1;
    end else begin
      old_stable = m_stable;
      old_color  = m_color;
      for (int i = 0; i < W; i++) begin
        if (m_s1[i] != m_stable[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DEB) begin
            m_stable[i] = m_s1[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      if (bus.frame_start && old_stable != old_color) begin
        m_color = old_stable;
        m_upd   = 1'b1;
      end else begin
        m_upd = 1'b0;
      end
      m_pend = (old_stable != m_color);
      m_s1 = m_s0;
      m_s0 = bus.sw_raw;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and compare every output with the model.
  task automatic tick();
    @(negedge clk);
    if (m_valid) begin
      chk("model_color",  32'(bus.color),        32'(m_color));
      chk("model_update", 32'(bus.color_update), 32'(m_upd));
      chk("model_pending",32'(bus.pending),      32'(m_pend));
    end
  endtask

  task automatic frame();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  initial begin
    int k;
    aresetn = 1'b0;
    bus.sw_raw = '0;
    bus.frame_start = 1'b0;
    tick();
    chk("rst_color",   32'(bus.color),        32'h0F0F);
    chk("rst_update",  32'(bus.color_update), 32'h0);
    chk("rst_pending", 32'(bus.pending),      32'h0);
    aresetn = 1'b1;

    // 1: idle, then first frame commits the all-zero debounced value
    repeat (10) tick();
    chk("idle_color",  32'(bus.color),        32'h0F0F);
    chk("idle_update", 32'(bus.color_update), 32'h0);
    frame();
    chk("first_commit_color",  32'(bus.color),        32'h0);
    chk("first_commit_update", 32'(bus.color_update), 32'h1);

    // 2: clean step; pending rises the edge after the 6-cycle debounce
    bus.sw_raw = 16'hF00F;
    k = 0;
    while (k < 20 && bus.pending !== 1'b1) begin
      tick();
      k++;
    end
    chk("step_pending_latency", 32'(k), 32'd7);
    chk("step_color_held", 32'(bus.color), 32'h0);
    frame();
    chk("step_commit_color",   32'(bus.color),        32'hF00F);
    chk("step_commit_update",  32'(bus.color_update), 32'h1);
    chk("step_commit_pending", 32'(bus.pending),      32'h0);
    tick();
    chk("step_update_single", 32'(bus.color_update), 32'h0);

    // 3: bit 3 deviates for 3 cycles, five times, never long enough to land
    for (int r = 0; r < 5; r++) begin
      bus.sw_raw = 16'hF007;
      repeat (3) tick();
      bus.sw_raw = 16'hF00F;
      tick();
    end
    repeat (6) tick();
    chk("glitch_pending", 32'(bus.pending), 32'h0);
    frame();
    chk("glitch_no_update", 32'(bus.color_update), 32'h0);
    chk("glitch_color",     32'(bus.color),        32'hF00F);

    // 4: bit-0 acceptance on the same edge as frame_start
    bus.sw_raw = 16'hF00E;
    repeat (5) tick();
    frame();
    chk("coincide_color",  32'(bus.color),        32'hF00F);
    chk("coincide_update", 32'(bus.color_update), 32'h0);
    tick();
    chk("coincide_pending", 32'(bus.pending), 32'h1);
    frame();
    chk("late_commit_color",  32'(bus.color),        32'hF00E);
    chk("late_commit_update", 32'(bus.color_update), 32'h1);

    // 5: reset while pending and mid-count, then the debounce starts over
    bus.sw_raw = 16'hF10E;
    repeat (8) tick();
    chk("pre_reset_pending", 32'(bus.pending), 32'h1);
    bus.sw_raw = 16'hF30E;
    repeat (3) tick();
    aresetn = 1'b0;
    tick();
    chk("midrst_color",   32'(bus.color),   32'h0F0F);
    chk("midrst_pending", 32'(bus.pending), 32'h0);
    aresetn = 1'b1;
    repeat (4) tick();
    frame();
    chk("restart_commit_zero", 32'(bus.color),        32'h0);
    chk("restart_update",      32'(bus.color_update), 32'h1);
    tick();
    chk("restart_pending_e6", 32'(bus.pending), 32'h0);
    tick();
    chk("restart_pending_e7", 32'(bus.pending), 32'h1);
    frame();
    chk("restart_final_color", 32'(bus.color), 32'hF30E);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
